// File: rtl/rca_nibble_sequencer.sv
// Wide adder built from an external combinational 4-bit ripple-carry adder.
// One nibble is added per clock, least-significant first, with the carry
// chained through a register. Operands enter on a valid/ready port. The
// registered result leaves on a valid/ready port.
module rca_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 c_in,
  output logic [3:0]           rca_a,
  output logic [3:0]           rca_b,
  output logic                 rca_cin,
  input  logic [3:0]           rca_s,
  input  logic                 rca_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  logic                    carry_reg;
  logic                    cout_reg;
  logic [NIBBLES-1:0][3:0] a_reg;
  logic [NIBBLES-1:0][3:0] b_reg;
  logic [NIBBLES-1:0][3:0] sum_reg;

  // Handshake flags come straight from the state register.
  // This keeps in_valid and out_ready off every output path.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

  // Adder drive depends only on registers, so rca_* moves only at clock edges.
  always_comb begin
    rca_a   = 4'd0;
    rca_b   = 4'd0;
    rca_cin = 1'b0;
    if (state == S_ADD) begin
      rca_a   = a_reg[idx];
      rca_b   = b_reg[idx];
      rca_cin = carry_reg;
    end
  end

  // Sequencer FSM and datapath.
  // The result registers hold their value after the output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            carry_reg <= c_in;
            idx       <= '0;
            state     <= S_ADD;
          end
        end
        S_ADD: begin
          sum_reg[idx] <= rca_s;
          carry_reg    <= rca_cout;
          if (idx == LAST) begin
            cout_reg <= rca_cout;
            idx      <= '0;
            state    <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Bench for rca_nibble_sequencer. The external 4-bit adder is modelled here.
// Every expected value comes from whole-word arithmetic on the operands.
module tb_rca_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in, b_in;
  logic         c_in;
  logic [3:0]   rca_a, rca_b, rca_s;
  logic         rca_cin, rca_cout;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  rca_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
    .rca_s(rca_s), .rca_cout(rca_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  // Combinational RCA_4Bit stand-in
  always_comb {rca_cout, rca_s} = 5'(rca_a) + 5'(rca_b) + 5'(rca_cin);

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one operation through: check every nibble's adder drive, then the result.
  // out_ready is left at 0, so the result stays in DONE on return.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    longint unsigned mask, part, full;
    full = longint'(a) + longint'(b) + longint'(c);
    in_valid = 1'b1; a_in = a; b_in = b; c_in = c;
    tick();
    in_valid = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
    for (int i = 0; i < N; i++) begin
      mask = (64'd1 << (4 * i)) - 64'd1;
      part = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
      chk($sformatf("rca_a[%0d]", i), 32'(rca_a), 32'((longint'(a) >> (4 * i)) & 64'hF));
      chk($sformatf("rca_b[%0d]", i), 32'(rca_b), 32'((longint'(b) >> (4 * i)) & 64'hF));
      chk($sformatf("rca_cin[%0d]", i), 32'(rca_cin), 32'((part >> (4 * i)) & 64'd1));
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      chk("out_valid_busy", 32'(out_valid), 32'd0);
      tick();
    end
    chk("out_valid_done", 32'(out_valid), 32'd1);
    chk("sum", 32'(sum), 32'(full & ((64'd1 << W) - 64'd1)));
    chk("cout", 32'(cout), 32'((full >> W) & 64'd1));
  endtask

  // Complete the output handshake and confirm that the result is held in IDLE.
  task automatic drain(input logic [W-1:0] exp_sum, input logic exp_cout);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    chk("out_valid_idle", 32'(out_valid), 32'd0);
    chk("sum_hold", 32'(sum), 32'(exp_sum));
    chk("cout_hold", 32'(cout), 32'(exp_cout));
    chk("rca_a_idle", 32'(rca_a), 32'd0);
  endtask

  initial begin : main
    logic [W-1:0] ra, rb, held_sum;
    logic         rc, held_cout;
    logic [W:0]   ref_res;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; c_in = 1'b0;

    // Reset
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_rca_a", 32'(rca_a), 32'd0);
    chk("rst_rca_b", 32'(rca_b), 32'd0);
    chk("rst_rca_cin", 32'(rca_cin), 32'd0);

    // Directed cases
    run_op(16'h1234, 16'h4321, 1'b0); drain(16'h5555, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0); drain(16'h0000, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1); drain(16'hFFFF, 1'b1);
    run_op(16'h7777, 16'h7777, 1'b0); drain(16'hEEEE, 1'b0);

    // Backpressure: DONE holds while new operands are offered.
    run_op(16'hA5A5, 16'h1111, 1'b1);
    held_sum = sum; held_cout = cout;
    chk("bp_sum_ref", 32'(held_sum), 32'h0000B6B7);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a_in = W'($urandom); b_in = W'($urandom); c_in = 1'($urandom);
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'(held_sum));
      chk("bp_cout", 32'(cout), 32'(held_cout));
      chk("bp_rca_a", 32'(rca_a), 32'd0);
    end
    in_valid = 1'b0;
    drain(held_sum, held_cout);
    run_op(16'h0F0F, 16'h0101, 1'b0); drain(16'h1010, 1'b0);

    // Reset in the middle of an operation
    in_valid = 1'b1; a_in = 16'h1234; b_in = 16'h1111; c_in = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    for (int i = 0; i < N + 2; i++) begin
      chk("mid_rst_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    run_op(16'h00FF, 16'h0001, 1'b0); drain(16'h0100, 1'b0);

    // Random operands checked against plain addition
    for (int t = 0; t < 24; t++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (t == 0) begin ra = '0; rb = '0; rc = 1'b0; end
      ref_res = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      run_op(ra, rb, rc);
      drain(ref_res[W-1:0], ref_res[W]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
